// File: rtl/alu_op_issue_stage.sv
// ID/EX issue stage: decodes RV64 opcode/funct3/funct7[5] into the 4-bit ALU op, selects operand B,
// and registers the result behind a valid/ready handshake with flush and saturating event counters.
module alu_op_issue_stage #(
  parameter int XLEN  = 64,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [6:0]       opcode,
  input  logic [2:0]       funct3,
  input  logic             funct7b5,
  input  logic [XLEN-1:0]  rs1_data,
  input  logic [XLEN-1:0]  rs2_data,
  input  logic [XLEN-1:0]  imm,
  input  logic [4:0]       rd,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  alu_a,
  output logic [XLEN-1:0]  alu_b,
  output logic [3:0]       alu_op,
  output logic [4:0]       rd_q,
  output logic             is_branch,
  output logic             br_on_zero,
  output logic             illegal,
  output logic [CNT_W-1:0] issued_cnt,
  output logic [CNT_W-1:0] illegal_cnt
);

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_I      = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_BLT = 4'b1000;
  localparam logic [3:0] OP_ILL = 4'b1111;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    if (c == {CNT_W{1'b1}}) begin
      return c;
    end else begin
      return c + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  endfunction

  logic             dec_use_imm_s;
  logic             dec_branch_s;
  logic             dec_bz_s;
  logic [3:0]       dec_op_s;
  logic             dec_illegal_s;
  logic [XLEN-1:0]  dec_b_s;
  logic             accept_s;

  logic             out_valid_q, out_valid_d;
  logic [XLEN-1:0]  alu_a_q, alu_b_q;
  logic [3:0]       alu_op_q;
  logic [4:0]       rd_q_q;
  logic             is_branch_q, br_on_zero_q, illegal_q;
  logic [CNT_W-1:0] issued_q, issued_d, illegal_cnt_q, illegal_cnt_d;

  // Instruction decode into ALU op, operand-B select and branch sense
  always_comb begin
    dec_op_s      = OP_ILL;
    dec_use_imm_s = 1'b0;
    dec_branch_s  = 1'b0;
    dec_bz_s      = 1'b0;
    case (opcode)
      OPC_R: begin
        case (funct3)
          3'b000:  dec_op_s = funct7b5 ? OP_SUB : OP_ADD;
          3'b111:  dec_op_s = OP_AND;
          3'b110:  dec_op_s = OP_OR;
          default: dec_op_s = OP_ILL;
        endcase
      end
      OPC_I: begin
        dec_use_imm_s = 1'b1;
        case (funct3)
          3'b000:  dec_op_s = OP_ADD;
          3'b111:  dec_op_s = OP_AND;
          3'b110:  dec_op_s = OP_OR;
          default: dec_op_s = OP_ILL;
        endcase
      end
      OPC_LOAD, OPC_STORE: begin
        dec_use_imm_s = 1'b1;
        dec_op_s      = OP_ADD;
      end
      OPC_BRANCH: begin
        // BEQ/BLT take the branch on ZERO=1, BNE on ZERO=0
        case (funct3)
          3'b000:  begin dec_op_s = OP_SUB; dec_branch_s = 1'b1; dec_bz_s = 1'b1; end
          3'b001:  begin dec_op_s = OP_SUB; dec_branch_s = 1'b1; dec_bz_s = 1'b0; end
          3'b100:  begin dec_op_s = OP_BLT; dec_branch_s = 1'b1; dec_bz_s = 1'b1; end
          default: dec_op_s = OP_ILL;
        endcase
      end
      default: dec_op_s = OP_ILL;
    endcase
  end

  assign dec_illegal_s = (dec_op_s == OP_ILL);
  assign dec_b_s       = dec_use_imm_s ? imm : rs2_data;
  assign in_ready      = ~out_valid_q | out_ready;
  assign accept_s      = in_valid & in_ready & ~flush;

  // Output-valid and counter next state; flush wins over everything
  always_comb begin
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (accept_s) begin
      out_valid_d = 1'b1;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
    issued_d      = (accept_s & ~dec_illegal_s) ? sat_inc(issued_q) : issued_q;
    illegal_cnt_d = (accept_s &  dec_illegal_s) ? sat_inc(illegal_cnt_q) : illegal_cnt_q;
  end

  // Handshake state, payload and counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q   <= 1'b0;
      alu_a_q       <= {XLEN{1'b0}};
      alu_b_q       <= {XLEN{1'b0}};
      alu_op_q      <= OP_ADD;
      rd_q_q        <= 5'd0;
      is_branch_q   <= 1'b0;
      br_on_zero_q  <= 1'b0;
      illegal_q     <= 1'b0;
      issued_q      <= {CNT_W{1'b0}};
      illegal_cnt_q <= {CNT_W{1'b0}};
    end else begin
      out_valid_q   <= out_valid_d;
      issued_q      <= issued_d;
      illegal_cnt_q <= illegal_cnt_d;
      if (accept_s) begin
        alu_a_q      <= rs1_data;
        alu_b_q      <= dec_b_s;
        alu_op_q     <= dec_op_s;
        rd_q_q       <= rd;
        is_branch_q  <= dec_branch_s;
        br_on_zero_q <= dec_bz_s;
        illegal_q    <= dec_illegal_s;
      end else begin
        alu_a_q      <= alu_a_q;
        alu_b_q      <= alu_b_q;
        alu_op_q     <= alu_op_q;
        rd_q_q       <= rd_q_q;
        is_branch_q  <= is_branch_q;
        br_on_zero_q <= br_on_zero_q;
        illegal_q    <= illegal_q;
      end
    end
  end

  assign out_valid   = out_valid_q;
  assign alu_a       = alu_a_q;
  assign alu_b       = alu_b_q;
  assign alu_op      = alu_op_q;
  assign rd_q        = rd_q_q;
  assign is_branch   = is_branch_q;
  assign br_on_zero  = br_on_zero_q;
  assign illegal     = illegal_q;
  assign issued_cnt  = issued_q;
  assign illegal_cnt = illegal_cnt_q;

endmodule

// File: tb/tb_alu_op_issue_stage.sv
// Scoreboard bench for alu_op_issue_stage: expected decode pushed on accept, compared on transfer,
// plus directed checks for stall, flush, counter saturation and asynchronous reset.
module tb_alu_op_issue_stage;

  typedef struct packed {
    logic [63:0] a;
    logic [63:0] b;
    logic [3:0]  op;
    logic [4:0]  rd;
    logic        ib;
    logic        bz;
    logic        ill;
  } exp_t;

  logic        clk, rst_n, in_valid, in_ready, funct7b5, flush, out_valid, out_ready;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [63:0] rs1_data, rs2_data, imm, alu_a, alu_b;
  logic [4:0]  rd, rd_q;
  logic [3:0]  alu_op;
  logic        is_branch, br_on_zero, illegal;
  logic [15:0] issued_cnt, illegal_cnt;

  int    n_tests = 0;
  int    n_fail  = 0;
  exp_t  sb[$];
  int    exp_issued  = 0;
  int    exp_illegal = 0;

  alu_op_issue_stage #(.XLEN(64), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .funct3(funct3), .funct7b5(funct7b5),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm), .rd(rd), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .alu_a(alu_a), .alu_b(alu_b),
    .alu_op(alu_op), .rd_q(rd_q), .is_branch(is_branch), .br_on_zero(br_on_zero),
    .illegal(illegal), .issued_cnt(issued_cnt), .illegal_cnt(illegal_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
    n_tests++;
    if (obs !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, want);
    end
  endtask

  function automatic exp_t model(input logic [6:0] opc, input logic [2:0] f3, input logic f7,
                                 input logic [63:0] a, input logic [63:0] b, input logic [63:0] im,
                                 input logic [4:0] r);
    exp_t e;
    e.a = a; e.b = b; e.rd = r; e.op = 4'hF; e.ib = 1'b0; e.bz = 1'b0;
    if (opc == 7'b0110011) begin
      if (f3 == 3'd0) e.op = f7 ? 4'b0110 : 4'b0010;
      else if (f3 == 3'd7) e.op = 4'b0000;
      else if (f3 == 3'd6) e.op = 4'b0001;
    end else if (opc == 7'b0010011) begin
      e.b = im;
      if (f3 == 3'd0) e.op = 4'b0010;
      else if (f3 == 3'd7) e.op = 4'b0000;
      else if (f3 == 3'd6) e.op = 4'b0001;
    end else if (opc == 7'b0000011 || opc == 7'b0100011) begin
      e.b = im; e.op = 4'b0010;
    end else if (opc == 7'b1100011) begin
      if (f3 == 3'd0)      begin e.op = 4'b0110; e.ib = 1'b1; e.bz = 1'b1; end
      else if (f3 == 3'd1) begin e.op = 4'b0110; e.ib = 1'b1; e.bz = 1'b0; end
      else if (f3 == 3'd4) begin e.op = 4'b1000; e.ib = 1'b1; e.bz = 1'b1; end
    end
    e.ill = (e.op == 4'hF);
    return e;
  endfunction

  // Scoreboard: compare on transfer, drop on flush, push on accept
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && (out_ready || flush)) begin
        if (sb.size() == 0) begin
          chk("sb_underflow", 64'd1, 64'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          if (out_ready) begin
            chk("sb_alu_a", alu_a, e.a);
            chk("sb_alu_b", alu_b, e.b);
            chk("sb_alu_op", alu_op, e.op);
            chk("sb_rd", rd_q, e.rd);
            chk("sb_is_branch", is_branch, e.ib);
            chk("sb_br_on_zero", br_on_zero, e.bz);
            chk("sb_illegal", illegal, e.ill);
          end
        end
      end
      if (in_valid && (!out_valid || out_ready) && !flush) begin
        exp_t e;
        e = model(opcode, funct3, funct7b5, rs1_data, rs2_data, imm, rd);
        sb.push_back(e);
        if (e.ill) begin
          if (exp_illegal < 65535) exp_illegal++;
        end else begin
          if (exp_issued < 65535) exp_issued++;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [6:0] opc, input logic [2:0] f3, input logic f7,
                       input logic [63:0] a, input logic [63:0] b, input logic [63:0] im,
                       input logic [4:0] r);
    in_valid = 1'b1; opcode = opc; funct3 = f3; funct7b5 = f7;
    rs1_data = a; rs2_data = b; imm = im; rd = r;
  endtask

  logic [10:0] tbl [13] = '{
    {7'b0110011, 3'd0, 1'b0}, {7'b0110011, 3'd7, 1'b0}, {7'b0110011, 3'd6, 1'b0},
    {7'b0110011, 3'd1, 1'b0}, {7'b0010011, 3'd6, 1'b0}, {7'b0010011, 3'd7, 1'b1},
    {7'b0010011, 3'd2, 1'b0}, {7'b0000011, 3'd3, 1'b0}, {7'b0100011, 3'd2, 1'b1},
    {7'b1100011, 3'd0, 1'b0}, {7'b1100011, 3'd4, 1'b0}, {7'b1100011, 3'd5, 1'b0},
    {7'b0110111, 3'd0, 1'b0}
  };

  initial begin
    logic [10:0] t;
    int cnt_before;
    rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    opcode = 7'd0; funct3 = 3'd0; funct7b5 = 1'b0;
    rs1_data = 64'd0; rs2_data = 64'd0; imm = 64'd0; rd = 5'd0;
    step(); step();
    rst_n = 1'b1;
    chk("rst_out_valid", out_valid, 64'd0);
    chk("rst_alu_a", alu_a, 64'd0);
    chk("rst_alu_b", alu_b, 64'd0);
    chk("rst_alu_op", alu_op, 64'd2);
    chk("rst_rd", rd_q, 64'd0);
    chk("rst_branch", {is_branch, br_on_zero, illegal}, 64'd0);
    chk("rst_cnts", {issued_cnt, illegal_cnt}, 64'd0);
    chk("rst_in_ready", in_ready, 64'd1);

    // SUB with rs1=10, rs2=3
    drive(7'b0110011, 3'd0, 1'b1, 64'd10, 64'd3, 64'd0, 5'd5);
    step();
    in_valid = 1'b0;
    chk("sub_valid", out_valid, 64'd1);
    chk("sub_op", alu_op, 64'b0110);
    chk("sub_a", alu_a, 64'd10);
    chk("sub_b", alu_b, 64'd3);
    step();

    // ADDI -1, BNE, illegal branch back to back
    drive(7'b0010011, 3'd0, 1'b1, 64'd7, 64'd9, 64'hFFFF_FFFF_FFFF_FFFF, 5'd1);
    step();
    chk("addi_op", alu_op, 64'b0010);
    chk("addi_b", alu_b, 64'hFFFF_FFFF_FFFF_FFFF);
    drive(7'b1100011, 3'd1, 1'b0, 64'd4, 64'd4, 64'd100, 5'd0);
    step();
    chk("bne_op", alu_op, 64'b0110);
    chk("bne_bz", br_on_zero, 64'd0);
    chk("bne_ib", is_branch, 64'd1);
    drive(7'b1100011, 3'd2, 1'b0, 64'd1, 64'd2, 64'd3, 5'd0);
    step();
    in_valid = 1'b0;
    chk("brill_op", alu_op, 64'hF);
    chk("brill_ill", illegal, 64'd1);
    chk("brill_ib", is_branch, 64'd0);
    chk("brill_cnt", illegal_cnt, 64'd1);
    chk("issued_3", issued_cnt, 64'd3);
    step();

    for (int i = 0; i < 13; i++) begin
      t = tbl[i];
      drive(t[10:4], t[3:1], t[0], {$urandom, $urandom}, {$urandom, $urandom},
            {$urandom, $urandom}, 5'(i + 3));
      step();
    end
    in_valid = 1'b0;
    step();
    chk("tbl_issued", issued_cnt, 64'(exp_issued));
    chk("tbl_illegal", illegal_cnt, 64'(exp_illegal));

    // Stall three cycles, then back-to-back release
    out_ready = 1'b0;
    drive(7'b0110011, 3'd7, 1'b0, 64'hA, 64'h1, 64'h0, 5'd10);
    step();
    drive(7'b0110011, 3'd6, 1'b0, 64'hB, 64'h2, 64'h0, 5'd11);
    for (int k = 0; k < 3; k++) begin
      chk("stall_in_ready", in_ready, 64'd0);
      chk("stall_hold_a", alu_a, 64'hA);
      chk("stall_valid", out_valid, 64'd1);
      step();
    end
    out_ready = 1'b1;
    #1;
    chk("release_in_ready", in_ready, 64'd1);
    step();
    chk("b2b_first", alu_a, 64'hB);
    chk("b2b_valid", out_valid, 64'd1);
    drive(7'b0010011, 3'd0, 1'b0, 64'hC, 64'h3, 64'h5, 5'd12);
    step();
    in_valid = 1'b0;
    chk("b2b_second", alu_a, 64'hC);
    chk("b2b_valid2", out_valid, 64'd1);
    step();

    // Flush with a held instruction and a new one offered
    out_ready = 1'b0;
    drive(7'b0110011, 3'd0, 1'b0, 64'hD, 64'h4, 64'h0, 5'd13);
    step();
    cnt_before = exp_issued;
    drive(7'b0110011, 3'd0, 1'b0, 64'hE, 64'h5, 64'h0, 5'd14);
    flush = 1'b1;
    #1;
    chk("flush_in_ready", in_ready, 64'd0);
    step();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_valid", out_valid, 64'd0);
    chk("flush_cnt", issued_cnt, 64'(cnt_before));
    out_ready = 1'b1;
    step();

    // Asynchronous reset while holding an instruction
    drive(7'b0110011, 3'd0, 1'b1, 64'h55, 64'h66, 64'h0, 5'd20);
    step();
    in_valid = 1'b0;
    chk("prerst_valid", out_valid, 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", out_valid, 64'd0);
    chk("arst_a", alu_a, 64'd0);
    chk("arst_op", alu_op, 64'd2);
    chk("arst_cnt", issued_cnt, 64'd0);
    sb.delete();
    exp_issued = 0;
    exp_illegal = 0;
    step();
    rst_n = 1'b1;
    step();

    // Counter saturation
    drive(7'b0110011, 3'd0, 1'b0, 64'h1, 64'h2, 64'h0, 5'd1);
    for (int n = 0; n < 32'hFFFE; n++) begin
      step();
    end
    in_valid = 1'b0;
    chk("pre_sat", issued_cnt, 64'hFFFE);
    drive(7'b0010011, 3'd7, 1'b0, 64'h3, 64'h4, 64'h7, 5'd2);
    for (int n = 0; n < 3; n++) begin
      step();
    end
    in_valid = 1'b0;
    chk("sat", issued_cnt, 64'hFFFF);
    chk("sat_illegal_clean", illegal_cnt, 64'd0);
    step();
    chk("sat_hold", issued_cnt, 64'hFFFF);
    chk("sb_drained", sb.size(), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
